// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo: per-instruction retire trace records buffered in a valid/ready FIFO; optional TRACE_CYCLE_STAMP_EN adds a capture cycle stamp
module retire_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ret_valid,
  input  logic [15:0]      ret_pc,
  input  logic             ret_regwrite,
  input  logic [2:0]       ret_wreg,
  input  logic [15:0]      ret_wdata,
  input  logic             ret_memread,
  input  logic             ret_memwrite,
  input  logic [15:0]      ret_maddr,
  input  logic [15:0]      ret_mdata,
  input  logic             ret_halt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_inum,
  output logic [2:0]       out_kind,
  output logic [15:0]      out_pc,
  output logic [2:0]       out_wreg,
  output logic [15:0]      out_wdata,
  output logic [15:0]      out_maddr,
  output logic [15:0]      out_mdata,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow,
  output logic             done
`ifdef TRACE_CYCLE_STAMP_EN
  , output logic [CNT_W-1:0] out_cycle
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  typedef struct packed {
    logic [CNT_W-1:0] inum;
    logic [2:0]       kind;
    logic [15:0]      pc;
    logic [2:0]       wreg;
    logic [15:0]      wdata;
    logic [15:0]      maddr;
    logic [15:0]      mdata;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [CNT_W-1:0] cyc;
`endif
  } rec_t;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state;
  rec_t mem [DEPTH];
  rec_t cap, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ, occ_pop;
  logic [CNT_W-1:0] inum;
  logic [2:0] kind;
  logic take, pop, admit, has_reg, has_addr, has_data;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [CNT_W-1:0] cycle;
`endif
  assign out_valid = occ != '0;
  assign head = mem[rd_ptr];
  assign out_inum = out_valid ? head.inum : '0;
  assign out_kind = out_valid ? head.kind : '0;
  assign out_pc = out_valid ? head.pc : '0;
  assign out_wreg = out_valid ? head.wreg : '0;
  assign out_wdata = out_valid ? head.wdata : '0;
  assign out_maddr = out_valid ? head.maddr : '0;
  assign out_mdata = out_valid ? head.mdata : '0;
`ifdef TRACE_CYCLE_STAMP_EN
  assign out_cycle = out_valid ? head.cyc : '0;
`endif
  // Classify the retiring instruction, zero unused fields, and decide admission after any same-cycle pop
  always_comb begin
    kind = ret_halt ? 3'd5 : (ret_regwrite & ret_memwrite) ? 3'd4 : ret_memwrite ? 3'd3 :
           (ret_regwrite & ret_memread) ? 3'd2 : ret_regwrite ? 3'd1 : 3'd0;
    has_reg = kind == 3'd1 || kind == 3'd2 || kind == 3'd4;
    has_addr = kind == 3'd2 || kind == 3'd3 || kind == 3'd4;
    has_data = kind == 3'd3 || kind == 3'd4;
    cap = '0;
    cap.inum = inum;
    cap.kind = kind;
    cap.pc = ret_pc;
    cap.wreg = has_reg ? ret_wreg : '0;
    cap.wdata = has_reg ? ret_wdata : '0;
    cap.maddr = has_addr ? ret_maddr : '0;
    cap.mdata = has_data ? ret_mdata : '0;
`ifdef TRACE_CYCLE_STAMP_EN
    cap.cyc = cycle;
`endif
    take = ret_valid && state == RUN;
    pop = out_valid && out_ready;
    occ_pop = occ - OW'(pop);
    admit = take && (occ_pop < (ret_halt ? OW'(DEPTH) : OW'(DEPTH - 1)));
  end
  // Record storage; pointers are reset so stale contents never become visible
  always_ff @(posedge clk) begin
    if (admit) mem[wr_ptr] <= cap;
  end
  // Pointers, occupancy, counters and the RUN/DRAIN/DONE sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      inum <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
      done <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(admit);
      rd_ptr <= rd_ptr + AW'(pop);
      occ <= occ_pop + OW'(admit);
      inum <= inum + CNT_W'(take);
      if (take && !admit) begin
        overflow <= 1'b1;
        drop_cnt <= &drop_cnt ? drop_cnt : drop_cnt + CNT_W'(1);
      end
      case (state)
        RUN: if (admit && ret_halt) state <= DRAIN;
        DRAIN: if (pop && occ == OW'(1)) begin
          state <= DONE;
          done <= 1'b1;
        end
        default: state <= DONE;
      endcase
    end
  end
`ifdef TRACE_CYCLE_STAMP_EN
  // Free-running capture timestamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle <= '0;
    else cycle <= cycle + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_retire_trace_fifo.sv
// tb_retire_trace_fifo: randomized checks of retire_trace_fifo against a queue-based trace model
module tb_retire_trace_fifo;
  logic clk = 0, rst_n = 0, ret_valid = 0, ret_regwrite = 0, ret_memread = 0, ret_memwrite = 0, ret_halt = 0, out_ready = 0;
  logic [15:0] ret_pc = 0, ret_wdata = 0, ret_maddr = 0, ret_mdata = 0;
  logic [2:0] ret_wreg = 0;
  logic out_valid, overflow, done;
  logic [15:0] out_inum, out_pc, out_wdata, out_maddr, out_mdata, drop_cnt;
  logic [2:0] out_kind, out_wreg;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [15:0] out_cycle;
`endif
  logic [127:0] act;
  int vecs = 0, errs = 0;
  typedef struct packed {
    logic [15:0] inum;
    logic [2:0]  kind;
    logic [15:0] pc;
    logic [2:0]  wreg;
    logic [15:0] wdata, maddr, mdata, cyc;
  } mrec_t;
  mrec_t q[$];
  int phase = 0;
  logic [15:0] minum = 0, mdrop = 0, mcyc = 0;
  logic movf = 0;

  retire_trace_fifo dut (
    .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_regwrite(ret_regwrite),
    .ret_wreg(ret_wreg), .ret_wdata(ret_wdata), .ret_memread(ret_memread), .ret_memwrite(ret_memwrite),
    .ret_maddr(ret_maddr), .ret_mdata(ret_mdata), .ret_halt(ret_halt), .out_valid(out_valid),
    .out_ready(out_ready), .out_inum(out_inum), .out_kind(out_kind), .out_pc(out_pc), .out_wreg(out_wreg),
    .out_wdata(out_wdata), .out_maddr(out_maddr), .out_mdata(out_mdata), .drop_cnt(drop_cnt),
    .overflow(overflow), .done(done)
`ifdef TRACE_CYCLE_STAMP_EN
    , .out_cycle(out_cycle)
`endif
  );

  always #5 clk = ~clk;

`ifdef TRACE_CYCLE_STAMP_EN
  assign act = {out_valid, out_inum, out_kind, out_pc, out_wreg, out_wdata, out_maddr, out_mdata, drop_cnt, overflow, done, out_cycle};
`else
  assign act = {out_valid, out_inum, out_kind, out_pc, out_wreg, out_wdata, out_maddr, out_mdata, drop_cnt, overflow, done};
`endif

  function automatic logic [127:0] expv();
    mrec_t h = q.size() > 0 ? q[0] : '0;
`ifdef TRACE_CYCLE_STAMP_EN
    return {q.size() > 0, h.inum, h.kind, h.pc, h.wreg, h.wdata, h.maddr, h.mdata, mdrop, movf, phase == 2, h.cyc};
`else
    return {q.size() > 0, h.inum, h.kind, h.pc, h.wreg, h.wdata, h.maddr, h.mdata, mdrop, movf, phase == 2};
`endif
  endfunction

  task automatic model_clear();
    q.delete();
    phase = 0;
    minum = 0;
    mdrop = 0;
    mcyc = 0;
    movf = 0;
  endtask

  task automatic tick();
    mrec_t r, gone;
    int ph, k;
    @(posedge clk);
    if (rst_n) begin
      ph = phase;
      if (q.size() > 0 && out_ready) begin
        gone = q.pop_front();
        if (ph == 1 && q.size() == 0) phase = 2;
      end
      if (ret_valid && ph == 0) begin
        if (ret_halt) k = 5;
        else if (ret_regwrite && ret_memwrite) k = 4;
        else if (ret_memwrite) k = 3;
        else if (ret_regwrite && ret_memread) k = 2;
        else if (ret_regwrite) k = 1;
        else k = 0;
        r = '0;
        r.inum = minum;
        r.kind = 3'(k);
        r.pc = ret_pc;
        r.cyc = mcyc;
        if (k inside {1, 2, 4}) begin
          r.wreg = ret_wreg;
          r.wdata = ret_wdata;
        end
        if (k inside {2, 3, 4}) r.maddr = ret_maddr;
        if (k inside {3, 4}) r.mdata = ret_mdata;
        minum++;
        if (q.size() < (ret_halt ? 16 : 15)) begin
          q.push_back(r);
          if (ret_halt) phase = 1;
        end else begin
          movf = 1;
          if (mdrop != 16'hFFFF) mdrop++;
        end
      end
      mcyc++;
    end
    #1;
  endtask

  task automatic set_rand(input bit allow_halt);
    ret_valid = 1;
    ret_pc = 16'($urandom);
    ret_regwrite = 1'($urandom);
    ret_memread = 1'($urandom);
    ret_memwrite = 1'($urandom);
    ret_wreg = 3'($urandom);
    ret_wdata = 16'($urandom);
    ret_maddr = 16'($urandom);
    ret_mdata = 16'($urandom);
    ret_halt = allow_halt && ($urandom_range(0, 15) == 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    ret_valid = 0;
    ret_halt = 0;
    model_clear();
    #1;
    vecs++;
    if (act !== expv()) begin errs++; $display("FAIL reset_state: got %h want %h", act, expv()); end
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    vecs++;
    if (act !== expv()) begin errs++; $display("FAIL reset_idle: got %h want %h", act, expv()); end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      ret_valid = i < 3;
      ret_halt = 0;
      ret_regwrite = i < 2;
      ret_memread = i == 1;
      ret_memwrite = i == 2;
      ret_pc = 16'(i * 2);
      ret_wreg = i == 0 ? 3'd2 : 3'd3;
      ret_wdata = i == 0 ? 16'h1234 : 16'h5555;
      ret_maddr = i == 1 ? 16'h0010 : 16'h0020;
      ret_mdata = 16'hBEEF;
      tick();
      vecs++;
      if (act !== expv()) begin errs++; $display("FAIL basic[%0d]: got %h want %h", i, act, expv()); end
    end
    vecs++;
    if (drop_cnt !== 16'd0) begin errs++; $display("FAIL basic_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_overflow_halt();
    int n;
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 20; i++) begin
      set_rand(0);
      tick();
      vecs++;
      if (act !== expv()) begin errs++; $display("FAIL fill[%0d]: got %h want %h", i, act, expv()); end
    end
    vecs++;
    if (drop_cnt !== 16'd5 || overflow !== 1'b1) begin errs++; $display("FAIL drop5: got %0d/%b want 5/1", drop_cnt, overflow); end
    set_rand(0);
    ret_halt = 1;
    tick();
    vecs++;
    if (act !== expv()) begin errs++; $display("FAIL halt_admit: got %h want %h", act, expv()); end
    out_ready = 1;
    n = 0;
    while (!(phase == 2 && n > 0) && n < 40) begin
      if (n < 5) set_rand(1);
      else ret_valid = 0;
      tick();
      n++;
      vecs++;
      if (act !== expv()) begin errs++; $display("FAIL drain[%0d]: got %h want %h", n, act, expv()); end
    end
    vecs++;
    if (n != 16 || done !== 1'b1) begin errs++; $display("FAIL drain_len: got %0d/%b want 16/1", n, done); end
    for (int i = 0; i < 3; i++) begin
      set_rand(1);
      tick();
      vecs++;
      if (done !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL done_hold: got %b/%b want 1/0", done, out_valid); end
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 15; i++) begin
      set_rand(0);
      tick();
    end
    out_ready = 1;
    set_rand(0);
    tick();
    vecs++;
    if (act !== expv() || drop_cnt !== 16'd0) begin errs++; $display("FAIL push_pop_full: got %h want %h", act, expv()); end
    out_ready = 0;
    set_rand(0);
    tick();
    vecs++;
    if (drop_cnt !== 16'd1) begin errs++; $display("FAIL still_15: got %0d want 1", drop_cnt); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      set_rand(0);
      tick();
    end
    ret_valid = 0;
    out_ready = 1;
    tick();
    rst_n = 0;
    model_clear();
    #1;
    vecs++;
    if (out_valid !== 1'b0 || drop_cnt !== 16'd0) begin errs++; $display("FAIL mid_reset: got %b/%0d want 0/0", out_valid, drop_cnt); end
    #2 rst_n = 1;
    out_ready = 0;
    set_rand(0);
    tick();
    vecs++;
    if (out_inum !== 16'd0 || act !== expv()) begin errs++; $display("FAIL after_reset: got %h want %h", act, expv()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (phase == 2) do_reset();
      out_ready = 1'($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0) set_rand(i > 50);
      else ret_valid = 0;
      tick();
      vecs++;
      if (act !== expv()) begin errs++; $display("FAIL random[%0d]: got %h want %h", i, act, expv()); end
    end
  endtask

`ifdef TRACE_CYCLE_STAMP_EN
  task automatic test_cycle_stamp();
    do_reset();
    out_ready = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 2 || c == 7) set_rand(0);
      else ret_valid = 0;
      tick();
      vecs++;
      if (act !== expv()) begin errs++; $display("FAIL stamp[%0d]: got %h want %h", c, act, expv()); end
    end
    vecs++;
    if (out_cycle !== 16'd2) begin errs++; $display("FAIL stamp2: got %0d want 2", out_cycle); end
    out_ready = 1;
    ret_valid = 0;
    tick();
    vecs++;
    if (out_cycle !== 16'd7) begin errs++; $display("FAIL stamp7: got %0d want 7", out_cycle); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow_halt();
    test_full_push_pop();
    test_reset_mid_drain();
    test_random();
`ifdef TRACE_CYCLE_STAMP_EN
    test_cycle_stamp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
